// File: rtl/dmem_bridge.sv
// ---------------------------------------------------------------------------
// dmem_bridge
//
// Data-side memory bridge behind the mem-stage load/store port. It checks
// alignment, builds byte enables and lane-replicated store data, runs a
// two-phase (address, then data) handshake with the data memory, and returns
// the sign/zero-extended load result. The pipeline is stalled for the whole
// transaction.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   memen_i             mem stage holds a load/store this cycle
//   flush_i             mem stage is being flushed
//   op_i, addr_i        mem-stage opcode and effective address
//   wdata_i             store data
//   rdata_o             extended load result, registered, valid in DONE
//   adel_o / ades_o     load / store address error (combinational)
//   stall_o             hold the pipeline
//   mem_req, mem_wr, mem_be, mem_addr, mem_wdata   request to data memory
//   mem_addr_ok, mem_data_ok, mem_rdata            responses from data memory
//   dbgState            current FSM state (0 IDLE, 1 ADDR, 2 DATA, 3 DONE)
//
// Handshake: the address phase is a valid/ready pair. mem_req is valid and
// every request field is held constant until the cycle mem_addr_ok (ready)
// is seen high; the request is accepted on that rising edge. The data phase
// then completes on the first rising edge with mem_data_ok high while in
// DATA; mem_data_ok in any other state is ignored.
// ---------------------------------------------------------------------------
module dmem_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        memen_i,
    input  logic        flush_i,
    input  logic [5:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic        stall_o,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbgState
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } bridgeState_t;

    bridgeState_t state;
    logic         abort;
    logic [5:0]   capOp;
    logic [1:0]   capOff;

    // ---------------- request decode ----------------
    logic        isLoad;
    logic        isStore;
    logic        loadMisaligned;
    logic        storeMisaligned;
    logic        start;
    logic [3:0]  reqBe;
    logic [31:0] reqWdata;

    always_comb begin
        isLoad          = 1'b0;
        isStore         = 1'b0;
        loadMisaligned  = 1'b0;
        storeMisaligned = 1'b0;
        reqBe           = 4'b1111;
        reqWdata        = 32'h0;
        case (op_i)
            OP_LB, OP_LBU: isLoad = 1'b1;
            OP_LH, OP_LHU: begin
                isLoad         = 1'b1;
                loadMisaligned = addr_i[0];
            end
            OP_LW: begin
                isLoad         = 1'b1;
                loadMisaligned = (addr_i[1:0] != 2'b00);
            end
            OP_SB: begin
                isStore  = 1'b1;
                reqBe    = 4'b0001 << addr_i[1:0];
                reqWdata = {4{wdata_i[7:0]}};
            end
            OP_SH: begin
                isStore         = 1'b1;
                storeMisaligned = addr_i[0];
                reqBe           = addr_i[1] ? 4'b1100 : 4'b0011;
                reqWdata        = {2{wdata_i[15:0]}};
            end
            OP_SW: begin
                isStore         = 1'b1;
                storeMisaligned = (addr_i[1:0] != 2'b00);
                reqWdata        = wdata_i;
            end
            default: ;
        endcase
    end

    // Gated by rst so that nothing combinational leaks out while held in reset.
    assign adel_o  = rst & memen_i & isLoad & loadMisaligned;
    assign ades_o  = rst & memen_i & isStore & storeMisaligned;
    assign start   = rst & memen_i & (isLoad | isStore) & ~adel_o & ~ades_o
                   & ~flush_i & (state == IDLE);
    assign stall_o = start | (state == ADDR) | (state == DATA);
    assign dbgState = state;

    // ---------------- load extraction (from captured op/offset) ----------------
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadData;
    logic        capIsLoad;

    always_comb begin
        loadByte = mem_rdata[7:0];
        case (capOff)
            2'd0:    loadByte = mem_rdata[7:0];
            2'd1:    loadByte = mem_rdata[15:8];
            2'd2:    loadByte = mem_rdata[23:16];
            default: loadByte = mem_rdata[31:24];
        endcase
        loadHalf = capOff[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (capOp)
            OP_LB:   loadData = {{24{loadByte[7]}}, loadByte};
            OP_LBU:  loadData = {24'h0, loadByte};
            OP_LH:   loadData = {{16{loadHalf[15]}}, loadHalf};
            OP_LHU:  loadData = {16'h0, loadHalf};
            default: loadData = mem_rdata;
        endcase
    end

    assign capIsLoad = (capOp == OP_LB) | (capOp == OP_LBU) | (capOp == OP_LH)
                     | (capOp == OP_LHU) | (capOp == OP_LW);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            abort     <= 1'b0;
            rdata_o   <= 32'h0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            capOp     <= 6'h0;
            capOff    <= 2'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ADDR;
                        abort     <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_wr    <= isStore;
                        mem_be    <= reqBe;
                        mem_addr  <= {addr_i[31:2], 2'b00};
                        mem_wdata <= reqWdata;
                        capOp     <= op_i;
                        capOff    <= addr_i[1:0];
                    end
                end
                ADDR: begin
                    if (mem_addr_ok) begin
                        // Accepted: a flush in this same cycle must still drain.
                        state   <= DATA;
                        mem_req <= 1'b0;
                        abort   <= flush_i;
                    end else if (flush_i) begin
                        // Not yet accepted, so the request can simply be withdrawn.
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                DATA: begin
                    if (flush_i) begin
                        abort <= 1'b1;
                    end
                    if (mem_data_ok) begin
                        abort <= 1'b0;
                        if (abort | flush_i) begin
                            state <= IDLE;
                        end else begin
                            state <= DONE;
                            if (capIsLoad) begin
                                rdata_o <= loadData;
                            end
                        end
                    end
                end
                DONE: begin
                    // memen_i is not looked at here, so the finished
                    // instruction cannot restart itself.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// ---------------------------------------------------------------------------
// tb_dmem_bridge
//
// Directed bench for dmem_bridge. A per-cycle memory responder drives
// mem_addr_ok / mem_data_ok at cycle indices fixed by each vector, so every
// wait is bounded. Expected load results go through an expected queue.
// ---------------------------------------------------------------------------
module tb_dmem_bridge;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd3;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        memen_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [5:0]  op_i = 6'h0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [31:0] rdata_o;
    logic        adel_o;
    logic        ades_o;
    logic        stall_o;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok = 1'b0;
    logic        mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [1:0]  dbgState;

    dmem_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .memen_i     (memen_i),
        .flush_i     (flush_i),
        .op_i        (op_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .adel_o      (adel_o),
        .ades_o      (ades_o),
        .stall_o     (stall_o),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata),
        .dbgState    (dbgState)
    );

    // ---------------- scoreboard ----------------
    int          checkCnt = 0;
    int          passCnt  = 0;
    logic [31:0] expQ[$];
    logic [31:0] lastRdata = 32'h0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    // One access. Cycle 0 is the start cycle, ADDR runs from cycle 1 to the
    // addr_ok cycle, DATA runs up to the data_ok cycle, and the cycle after
    // that is DONE (or IDLE when flushed).
    task automatic doAccess(input string name, input logic [5:0] op,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rword, input int addrWait,
                            input int dataDelay, input int flushAt,
                            input logic [3:0] expBe, input logic expWr,
                            input logic [31:0] expWdata, input bit chkWdata,
                            input int expStall, input bit isLoadOp,
                            input logic [31:0] loadVal);
        int stallCnt = 0;
        int aokCyc   = 1 + addrWait;
        int dokCyc   = 1 + addrWait + dataDelay;
        int last     = 2 + addrWait + dataDelay;
        bit flushed  = 1'b0;
        bit chkRd    = isLoadOp || (flushAt >= 0);
        if (isLoadOp && flushAt < 0) lastRdata = loadVal;
        if (chkRd) expQ.push_back(lastRdata);
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            if (c == flushAt) flushed = 1'b1;
            flush_i     = (c == flushAt);
            memen_i     = !flushed;
            op_i        = op;
            addr_i      = addr;
            wdata_i     = wdata;
            mem_addr_ok = (c == aokCyc);
            mem_data_ok = (c == dokCyc);
            mem_rdata   = (c == dokCyc) ? rword : ~rword;
            #1;
            if (stall_o) stallCnt++;
            if (c >= 1 && c <= aokCyc) begin
                checkVal({name, ".req"},  mem_req,  1'b1);
                checkVal({name, ".addr"}, mem_addr, addr & 32'hFFFF_FFFC);
                checkVal({name, ".be"},   mem_be,   expBe);
                checkVal({name, ".wr"},   mem_wr,   expWr);
                if (chkWdata) checkVal({name, ".wdata"}, mem_wdata, expWdata);
            end
            if (c == dokCyc) checkVal({name, ".reqdrop"}, mem_req, 1'b0);
            if (c == last) begin
                checkVal({name, ".stallend"}, stall_o, 1'b0);
                checkVal({name, ".state"}, dbgState, (flushAt >= 0) ? ST_IDLE : ST_DONE);
                if (chkRd) checkVal({name, ".rdata"}, rdata_o, expQ.pop_front());
            end
        end
        @(negedge clk);
        memen_i     = 1'b0;
        flush_i     = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        #1;
        checkVal({name, ".stallcnt"}, stallCnt, expStall);
        checkVal({name, ".idle"}, dbgState, ST_IDLE);
    endtask

    // A single-cycle presentation that must not start a transaction.
    task automatic doNoAccess(input string name, input logic [5:0] op,
                              input logic [31:0] addr, input logic memen,
                              input logic expAdel, input logic expAdes);
        @(negedge clk);
        memen_i = memen;
        flush_i = 1'b0;
        op_i    = op;
        addr_i  = addr;
        #1;
        checkVal({name, ".adel"},  adel_o,  expAdel);
        checkVal({name, ".ades"},  ades_o,  expAdes);
        checkVal({name, ".stall"}, stall_o, 1'b0);
        @(negedge clk);
        #1;
        checkVal({name, ".noreq"}, mem_req,  1'b0);
        checkVal({name, ".idle"},  dbgState, ST_IDLE);
        memen_i = 1'b0;
    endtask

    // ---------------- sequence ----------------
    initial begin
        #23;
        checkVal("rst.rdata", rdata_o,   32'h0);
        checkVal("rst.req",   mem_req,   1'b0);
        checkVal("rst.wr",    mem_wr,    1'b0);
        checkVal("rst.be",    mem_be,    4'h0);
        checkVal("rst.addr",  mem_addr,  32'h0);
        checkVal("rst.wdata", mem_wdata, 32'h0);
        checkVal("rst.stall", stall_o,   1'b0);
        checkVal("rst.adel",  adel_o,    1'b0);
        checkVal("rst.ades",  ades_o,    1'b0);
        @(negedge clk);
        rst = 1'b1;

        // name, op, addr, wdata, rword, aw, dd, flushAt, be, wr, wdata, chkW, stall, load, value
        doAccess("lw",  OP_LW,  32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 1, -1, 4'b1111, 1'b0, 32'h0, 1'b0, 3, 1'b1, 32'hDEAD_BEEF);
        doAccess("lb",  OP_LB,  32'h0000_1003, 32'h0, 32'h8012_3456, 0, 1, -1, 4'b1111, 1'b0, 32'h0, 1'b0, 3, 1'b1, 32'hFFFF_FF80);
        doAccess("lbu", OP_LBU, 32'h0000_1003, 32'h0, 32'h8012_3456, 0, 1, -1, 4'b1111, 1'b0, 32'h0, 1'b0, 3, 1'b1, 32'h0000_0080);
        doAccess("lh",  OP_LH,  32'h0000_1002, 32'h0, 32'h8001_1234, 0, 1, -1, 4'b1111, 1'b0, 32'h0, 1'b0, 3, 1'b1, 32'hFFFF_8001);
        doAccess("lhu", OP_LHU, 32'h0000_1000, 32'h0, 32'h1234_F00D, 0, 1, -1, 4'b1111, 1'b0, 32'h0, 1'b0, 3, 1'b1, 32'h0000_F00D);
        doAccess("lb1", OP_LB,  32'h0000_1001, 32'h0, 32'h0000_7F00, 0, 1, -1, 4'b1111, 1'b0, 32'h0, 1'b0, 3, 1'b1, 32'h0000_007F);
        doAccess("sb",  OP_SB,  32'h0000_2002, 32'h0000_00A5, 32'h0, 0, 1, -1, 4'b0100, 1'b1, 32'hA5A5_A5A5, 1'b1, 3, 1'b0, 32'h0);
        doAccess("sh",  OP_SH,  32'h0000_2002, 32'h0000_1234, 32'h0, 0, 1, -1, 4'b1100, 1'b1, 32'h1234_1234, 1'b1, 3, 1'b0, 32'h0);
        doAccess("shlo", OP_SH, 32'h0000_2000, 32'hFFFF_BEEF, 32'h0, 0, 1, -1, 4'b0011, 1'b1, 32'hBEEF_BEEF, 1'b1, 3, 1'b0, 32'h0);
        doAccess("sw",  OP_SW,  32'h0000_3000, 32'hCAFE_F00D, 32'h0, 0, 1, -1, 4'b1111, 1'b1, 32'hCAFE_F00D, 1'b1, 3, 1'b0, 32'h0);

        doNoAccess("lwmis", OP_LW,  32'h0000_1002, 1'b1, 1'b1, 1'b0);
        doNoAccess("lhmis", OP_LH,  32'h0000_1001, 1'b1, 1'b1, 1'b0);
        doNoAccess("shmis", OP_SH,  32'h0000_2001, 1'b1, 1'b0, 1'b1);
        doNoAccess("swmis", OP_SW,  32'h0000_2003, 1'b1, 1'b0, 1'b1);
        doNoAccess("gated", OP_LW,  32'h0000_1002, 1'b0, 1'b0, 1'b0);
        doNoAccess("noop",  6'b000000, 32'h0000_1000, 1'b1, 1'b0, 1'b0);

        // Slow memory: addr_ok 2 cycles after mem_req rises, data_ok 3 after addr_ok.
        doAccess("slow", OP_LW, 32'h0000_4008, 32'h0, 32'h0BAD_CAFE, 2, 3, -1, 4'b1111, 1'b0, 32'h0, 1'b0, 7, 1'b1, 32'h0BAD_CAFE);
        // Flush during DATA: drains to data_ok, rdata_o keeps the previous load.
        doAccess("flush", OP_LW, 32'h0000_5000, 32'h0, 32'h1111_2222, 0, 3, 3, 4'b1111, 1'b0, 32'h0, 1'b0, 5, 1'b1, 32'h1111_2222);

        // Reset asserted while the request is outstanding in ADDR.
        @(negedge clk);
        memen_i = 1'b1; op_i = OP_LW; addr_i = 32'h0000_1008;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        #1;
        checkVal("rstaddr.start", stall_o, 1'b1);
        @(negedge clk);
        #1;
        checkVal("rstaddr.req", mem_req, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkVal("rstaddr.reqlow",   mem_req,  1'b0);
        checkVal("rstaddr.stalllow", stall_o,  1'b0);
        checkVal("rstaddr.idle",     dbgState, ST_IDLE);
        @(negedge clk);
        memen_i = 1'b0;
        rst = 1'b1;
        lastRdata = 32'h0;
        checkVal("rstaddr.rdata", rdata_o, 32'h0);

        doAccess("after", OP_LHU, 32'h0000_1002, 32'h0, 32'hABCD_0123, 0, 1, -1, 4'b1111, 1'b0, 32'h0, 1'b0, 3, 1'b1, 32'h0000_ABCD);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
